// File: rtl/quant_arb_pkg.sv
// -----------------------------------------------------------------------------
// quant_arb_pkg
// Shared ACO definitions for the quantizer arbiter slice:
//   - default input/output sample widths
//   - arbiter state encoding (IDLE=0, BUSY=1)
//   - clip limits of a signed O_BW-bit result, as functions of the width
// -----------------------------------------------------------------------------
package quant_arb_pkg;

    localparam int ACO_I_BW = 32'sd16;
    localparam int ACO_O_BW = 32'sd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Largest value representable in a signed o_bw-bit sample (127 for 8 bits).
    function automatic int clip_max(input int o_bw);
        return (32'sd1 <<< (o_bw - 32'sd1)) - 32'sd1;
    endfunction

    // Smallest value representable in a signed o_bw-bit sample (-128 for 8 bits).
    function automatic int clip_min(input int o_bw);
        return -(32'sd1 <<< (o_bw - 32'sd1));
    endfunction

endpackage

// File: rtl/quant_arb_quant.sv
// -----------------------------------------------------------------------------
// quant
// Combinational signed saturating quantizer, I_BW bits in, O_BW bits out.
// Values above the O_BW range clip to the maximum, values below clip to the
// minimum, everything else passes through as the low O_BW bits.
// Ports:
//   en_i   : enable; output is forced to zero when low
//   data_i : signed input sample
//   data_o : signed saturated sample
// -----------------------------------------------------------------------------
module quant
    import quant_arb_pkg::*;
#(
    parameter int I_BW = ACO_I_BW,
    parameter int O_BW = ACO_O_BW
) (
    input  logic            en_i,
    input  logic [I_BW-1:0] data_i,
    output logic [O_BW-1:0] data_o
);

    // Limits expressed at the input width so the comparisons stay signed and
    // width-matched.
    localparam logic signed [I_BW-1:0] LIM_MAX = I_BW'(clip_max(O_BW));
    localparam logic signed [I_BW-1:0] LIM_MIN = I_BW'(clip_min(O_BW));
    localparam logic [O_BW-1:0]        OUT_MAX = {1'b0, {(O_BW-1){1'b1}}};
    localparam logic [O_BW-1:0]        OUT_MIN = {1'b1, {(O_BW-1){1'b0}}};

    // Saturating narrow of the input sample.
    always_comb begin
        data_o = {O_BW{1'b0}};
        if (!en_i) begin
            data_o = {O_BW{1'b0}};
        end else if ($signed(data_i) > LIM_MAX) begin
            data_o = OUT_MAX;
        end else if ($signed(data_i) < LIM_MIN) begin
            data_o = OUT_MIN;
        end else begin
            data_o = data_i[O_BW-1:0];
        end
    end

endmodule

// File: rtl/quant_arb.sv
// -----------------------------------------------------------------------------
// quant_arb
// Frame-granular round-robin arbiter sharing one saturating quantizer among
// NUM_CH streaming requesters. A channel keeps the grant from its first
// accepted beat through its last beat; a frame that stalls for TIMEOUT cycles
// is dropped and abort_o pulses.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : allows new grants (a running frame always finishes)
//   data_i       : packed samples, channel k at [k*I_BW +: I_BW]
//   valid_i      : per-channel sample valid
//   last_i       : per-channel end of frame, qualified by valid
//   ready_o      : per-channel accept (one-hot while a frame is granted)
//   data_o       : registered saturated sample
//   valid_o      : data_o valid
//   last_o       : final beat of the frame
//   chan_o       : source channel of data_o
//   sat_cnt_o    : clipped-sample count of the frame, non-zero only with last_o
//   abort_o      : one-cycle pulse when a frame is dropped by timeout
// -----------------------------------------------------------------------------
module quant_arb
    import quant_arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int I_BW    = ACO_I_BW,
    parameter int O_BW    = ACO_O_BW,
    parameter int TIMEOUT = 255,
    parameter int SAT_BW  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [NUM_CH*I_BW-1:0]    data_i,
    input  logic [NUM_CH-1:0]         valid_i,
    input  logic [NUM_CH-1:0]         last_i,
    output logic [NUM_CH-1:0]         ready_o,
    output logic [O_BW-1:0]           data_o,
    output logic                      valid_o,
    output logic                      last_o,
    output logic [$clog2(NUM_CH)-1:0] chan_o,
    output logic [SAT_BW-1:0]         sat_cnt_o,
    output logic                      abort_o
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic signed [I_BW-1:0] LIM_MAX = I_BW'(clip_max(O_BW));
    localparam logic signed [I_BW-1:0] LIM_MIN = I_BW'(clip_min(O_BW));

    // First requester searching upward from ptr+1 with wrap-around, so the
    // channel that was served last has the lowest priority.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] pick;
        logic [CH_W-1:0] idx;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx   = CH_W'((int'(ptr) + i) % NUM_CH);
            pick  = (!found && req[idx]) ? idx : pick;
            found = found | req[idx];
        end
        return pick;
    endfunction

    arb_state_t          state_r, state_nxt_s;
    logic [CH_W-1:0]     gnt_r, gnt_nxt_s;
    logic [CH_W-1:0]     ptr_r, ptr_nxt_s;
    logic [NUM_CH-1:0]   ready_r, ready_nxt_s;
    logic [IDLE_W-1:0]   idle_cnt_r, idle_cnt_nxt_s;
    logic [SAT_BW-1:0]   sat_cnt_r, sat_cnt_nxt_s, sat_inc_s;

    logic [I_BW-1:0]     sample_s;
    logic [O_BW-1:0]     quant_s;
    logic                clip_s;
    logic                start_s;
    logic                accept_s;
    logic                last_beat_s;
    logic                timeout_s;

    logic [O_BW-1:0]     data_r, data_nxt_s;
    logic                valid_r, valid_nxt_s;
    logic                last_r, last_nxt_s;
    logic [CH_W-1:0]     chan_r, chan_nxt_s;
    logic [SAT_BW-1:0]   sat_out_r, sat_out_nxt_s;
    logic                abort_r, abort_nxt_s;

    // Select the granted channel's sample for the shared quantizer.
    always_comb begin
        sample_s = {I_BW{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            sample_s = (gnt_r == CH_W'(k)) ? data_i[k*I_BW +: I_BW] : sample_s;
        end
    end

    quant #(
        .I_BW (I_BW),
        .O_BW (O_BW)
    ) u_quant (
        .en_i   (1'b1),
        .data_i (sample_s),
        .data_o (quant_s)
    );

    // Handshake qualifiers; ready is high exactly on the granted channel in BUSY.
    always_comb begin
        clip_s      = ($signed(sample_s) > LIM_MAX) || ($signed(sample_s) < LIM_MIN);
        start_s     = (state_r == ST_IDLE) && en_i && (|valid_i);
        accept_s    = (state_r == ST_BUSY) && valid_i[gnt_r];
        last_beat_s = accept_s && last_i[gnt_r];
        // Fires on the stalled cycle that brings the idle count up to TIMEOUT.
        timeout_s   = (state_r == ST_BUSY) && !valid_i[gnt_r] &&
                      ((int'(idle_cnt_r) + 32'sd1) >= TIMEOUT);
        sat_inc_s   = (sat_cnt_r == {SAT_BW{1'b1}}) ? sat_cnt_r
                                                    : sat_cnt_r + SAT_BW'(1'b1);
    end

    // State, grant and priority-pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            gnt_r   <= {CH_W{1'b0}};
            ptr_r   <= CH_W'(NUM_CH - 1);
            ready_r <= {NUM_CH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
            ready_r <= ready_nxt_s;
        end
    end

    // Next-state logic: grant in IDLE, release on last beat or timeout.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_BUSY;
                    gnt_nxt_s   = rr_pick(valid_i, ptr_r);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_beat_s || timeout_s) begin
                    state_nxt_s = ST_IDLE;
                    ptr_nxt_s   = gnt_r;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        ready_nxt_s = (state_nxt_s == ST_BUSY)
                    ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gnt_nxt_s)
                    : {NUM_CH{1'b0}};
    end

    // Idle and clip counter updates; both restart when a frame is granted.
    always_comb begin
        idle_cnt_nxt_s = idle_cnt_r;
        sat_cnt_nxt_s  = sat_cnt_r;
        if (start_s) begin
            idle_cnt_nxt_s = {IDLE_W{1'b0}};
            sat_cnt_nxt_s  = {SAT_BW{1'b0}};
        end else if (state_r == ST_BUSY) begin
            if (accept_s) begin
                idle_cnt_nxt_s = {IDLE_W{1'b0}};
                sat_cnt_nxt_s  = clip_s ? sat_inc_s : sat_cnt_r;
            end else if (timeout_s) begin
                idle_cnt_nxt_s = {IDLE_W{1'b0}};
            end else begin
                idle_cnt_nxt_s = idle_cnt_r + IDLE_W'(1'b1);
            end
        end else begin
            idle_cnt_nxt_s = {IDLE_W{1'b0}};
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_cnt_r <= {IDLE_W{1'b0}};
            sat_cnt_r  <= {SAT_BW{1'b0}};
        end else begin
            idle_cnt_r <= idle_cnt_nxt_s;
            sat_cnt_r  <= sat_cnt_nxt_s;
        end
    end

    // Output decode: one registered beat per accepted input beat.
    always_comb begin
        data_nxt_s    = accept_s ? quant_s : {O_BW{1'b0}};
        chan_nxt_s    = accept_s ? gnt_r : {CH_W{1'b0}};
        valid_nxt_s   = accept_s;
        last_nxt_s    = last_beat_s;
        sat_out_nxt_s = last_beat_s ? sat_cnt_nxt_s : {SAT_BW{1'b0}};
        abort_nxt_s   = timeout_s;
    end

    // Output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_r    <= {O_BW{1'b0}};
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            chan_r    <= {CH_W{1'b0}};
            sat_out_r <= {SAT_BW{1'b0}};
            abort_r   <= 1'b0;
        end else begin
            data_r    <= data_nxt_s;
            valid_r   <= valid_nxt_s;
            last_r    <= last_nxt_s;
            chan_r    <= chan_nxt_s;
            sat_out_r <= sat_out_nxt_s;
            abort_r   <= abort_nxt_s;
        end
    end

    assign ready_o   = ready_r;
    assign data_o    = data_r;
    assign valid_o   = valid_r;
    assign last_o    = last_r;
    assign chan_o    = chan_r;
    assign sat_cnt_o = sat_out_r;
    assign abort_o   = abort_r;

endmodule
